// File: rtl/lab3_mem_cache_arbiter.sv
// Round-robin arbiter sharing one blocking cache between two requesters; zero-cycle pass-through both ways.
// Backpressure: requests stall when the in-order ID queue is full; a stalled head response blocks all later responses.
module lab3_mem_cache_arbiter #(
   parameter int p_req_nbits       = 78,
   parameter int p_resp_nbits      = 48,
   parameter int p_num_outstanding = 2
) (
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    proc0_reqstream_val,
   output logic                    proc0_reqstream_rdy,
   input  logic [p_req_nbits-1:0]  proc0_reqstream_msg,
   output logic                    proc0_respstream_val,
   input  logic                    proc0_respstream_rdy,
   output logic [p_resp_nbits-1:0] proc0_respstream_msg,

   input  logic                    proc1_reqstream_val,
   output logic                    proc1_reqstream_rdy,
   input  logic [p_req_nbits-1:0]  proc1_reqstream_msg,
   output logic                    proc1_respstream_val,
   input  logic                    proc1_respstream_rdy,
   output logic [p_resp_nbits-1:0] proc1_respstream_msg,

   output logic                    cache_reqstream_val,
   input  logic                    cache_reqstream_rdy,
   output logic [p_req_nbits-1:0]  cache_reqstream_msg,
   input  logic                    cache_respstream_val,
   output logic                    cache_respstream_rdy,
   input  logic [p_resp_nbits-1:0] cache_respstream_msg,

   output logic [2:0]              num_inflight
);

   localparam logic [2:0] DEPTH    = 3'(p_num_outstanding);
   localparam logic [1:0] LAST_PTR = 2'(p_num_outstanding - 1);

   logic       prio_q, prio_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [2:0] count_q, count_d;
   logic [3:0] ids_q, ids_d;

   logic full, empty;
   logic grant_vld, grant_id;
   logic head;
   logic req_fire, resp_fire;

   function automatic logic [1:0] ptr_next(input logic [1:0] ptr);
      return (ptr == LAST_PTR) ? 2'd0 : ptr + 2'd1;
   endfunction

   always_comb begin
      full  = (count_q == DEPTH);
      empty = (count_q == 3'd0);

      // With both valid, prio decides; otherwise the lone valid requester wins (0 when idle).
      grant_vld = proc0_reqstream_val | proc1_reqstream_val;
      if (proc0_reqstream_val && proc1_reqstream_val) begin
         grant_id = prio_q;
      end else begin
         grant_id = proc1_reqstream_val;
      end

      cache_reqstream_val = grant_vld & ~full;
      cache_reqstream_msg = grant_id ? proc1_reqstream_msg : proc0_reqstream_msg;
      proc0_reqstream_rdy = grant_vld & ~grant_id & cache_reqstream_rdy & ~full;
      proc1_reqstream_rdy = grant_vld &  grant_id & cache_reqstream_rdy & ~full;
      req_fire            = cache_reqstream_val & cache_reqstream_rdy;

      head                 = ids_q[rd_ptr_q];
      proc0_respstream_val = cache_respstream_val & ~empty & ~head;
      proc1_respstream_val = cache_respstream_val & ~empty &  head;
      proc0_respstream_msg = cache_respstream_msg;
      proc1_respstream_msg = cache_respstream_msg;
      cache_respstream_rdy = ~empty & (head ? proc1_respstream_rdy : proc0_respstream_rdy);
      resp_fire            = cache_respstream_val & cache_respstream_rdy;

      num_inflight = count_q;
   end

   always_comb begin
      prio_d   = prio_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ids_d    = ids_q;

      if (req_fire) begin
         ids_d[wr_ptr_q] = grant_id;
         wr_ptr_d        = ptr_next(wr_ptr_q);
         prio_d          = ~grant_id;
      end
      if (resp_fire) begin
         rd_ptr_d = ptr_next(rd_ptr_q);
      end

      case ({req_fire, resp_fire})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q   <= 1'b0;
         rd_ptr_q <= 2'd0;
         wr_ptr_q <= 2'd0;
         count_q  <= 3'd0;
         ids_q    <= 4'd0;
      end else begin
         prio_q   <= prio_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ids_q    <= ids_d;
      end
   end

endmodule

// File: tb/tb_lab3_mem_cache_arbiter.sv
// Scenario bench for lab3_mem_cache_arbiter; a scoreboard tracks expected cache requests and routed responses.
module tb_lab3_mem_cache_arbiter;

   localparam int RW = 78;
   localparam int SW = 48;

   logic          clk;
   logic          reset;
   logic          proc0_reqstream_val, proc0_reqstream_rdy;
   logic [RW-1:0] proc0_reqstream_msg;
   logic          proc0_respstream_val, proc0_respstream_rdy;
   logic [SW-1:0] proc0_respstream_msg;
   logic          proc1_reqstream_val, proc1_reqstream_rdy;
   logic [RW-1:0] proc1_reqstream_msg;
   logic          proc1_respstream_val, proc1_respstream_rdy;
   logic [SW-1:0] proc1_respstream_msg;
   logic          cache_reqstream_val, cache_reqstream_rdy;
   logic [RW-1:0] cache_reqstream_msg;
   logic          cache_respstream_val, cache_respstream_rdy;
   logic [SW-1:0] cache_respstream_msg;
   logic [2:0]    num_inflight;

   int checks = 0;
   int errors = 0;
   int resp_cnt0 = 0;
   int resp_cnt1 = 0;

   logic          exp_req_id[$];
   logic [RW-1:0] exp_req_msg[$];
   logic          exp_resp_id[$];
   logic [SW-1:0] exp_resp_msg[$];

   lab3_mem_cache_arbiter #(
      .p_req_nbits(RW), .p_resp_nbits(SW), .p_num_outstanding(2)
   ) dut (
      .clk(clk), .reset(reset),
      .proc0_reqstream_val(proc0_reqstream_val), .proc0_reqstream_rdy(proc0_reqstream_rdy),
      .proc0_reqstream_msg(proc0_reqstream_msg),
      .proc0_respstream_val(proc0_respstream_val), .proc0_respstream_rdy(proc0_respstream_rdy),
      .proc0_respstream_msg(proc0_respstream_msg),
      .proc1_reqstream_val(proc1_reqstream_val), .proc1_reqstream_rdy(proc1_reqstream_rdy),
      .proc1_reqstream_msg(proc1_reqstream_msg),
      .proc1_respstream_val(proc1_respstream_val), .proc1_respstream_rdy(proc1_respstream_rdy),
      .proc1_respstream_msg(proc1_respstream_msg),
      .cache_reqstream_val(cache_reqstream_val), .cache_reqstream_rdy(cache_reqstream_rdy),
      .cache_reqstream_msg(cache_reqstream_msg),
      .cache_respstream_val(cache_respstream_val), .cache_respstream_rdy(cache_respstream_rdy),
      .cache_respstream_msg(cache_respstream_msg),
      .num_inflight(num_inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [RW-1:0] rnd_req();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[RW-1:0];
   endfunction

   function automatic logic [SW-1:0] rnd_resp();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[SW-1:0];
   endfunction

   task automatic exp_req(input logic id, input logic [RW-1:0] m);
      exp_req_id.push_back(id);
      exp_req_msg.push_back(m);
   endtask

   task automatic exp_resp(input logic id, input logic [SW-1:0] m);
      exp_resp_id.push_back(id);
      exp_resp_msg.push_back(m);
   endtask

   // Scoreboard: pops and compares whenever a request or response handshake completes.
   task automatic mon();
      logic          id;
      logic [RW-1:0] rm;
      logic [SW-1:0] sm;
      logic          p0f, p1f;
      if (cache_reqstream_val && cache_reqstream_rdy) begin
         checks++;
         if (exp_req_id.size() == 0) begin
            errors++;
            $display("FAIL req_fire_unexpected got msg=%h want no request", cache_reqstream_msg);
         end else begin
            id = exp_req_id.pop_front();
            rm = exp_req_msg.pop_front();
            if ({proc1_reqstream_rdy, proc0_reqstream_rdy} !== (id ? 2'b10 : 2'b01) ||
                cache_reqstream_msg !== rm) begin
               errors++;
               $display("FAIL req_fire got rdy1/0=%b%b msg=%h want id=%0d msg=%h",
                        proc1_reqstream_rdy, proc0_reqstream_rdy, cache_reqstream_msg, id, rm);
            end
         end
      end
      p0f = proc0_respstream_val & proc0_respstream_rdy;
      p1f = proc1_respstream_val & proc1_respstream_rdy;
      if (p0f || p1f) begin
         checks++;
         if (exp_resp_id.size() == 0) begin
            errors++;
            $display("FAIL resp_fire_unexpected got p0=%b p1=%b want none", p0f, p1f);
         end else begin
            id = exp_resp_id.pop_front();
            sm = exp_resp_msg.pop_front();
            if ((p0f && p1f) || p1f !== id || cache_respstream_rdy !== 1'b1 ||
                proc0_respstream_msg !== sm || proc1_respstream_msg !== sm) begin
               errors++;
               $display("FAIL resp_fire got p0=%b p1=%b crdy=%b msg=%h/%h want id=%0d msg=%h",
                        p0f, p1f, cache_respstream_rdy, proc0_respstream_msg,
                        proc1_respstream_msg, id, sm);
            end
            if (p1f) resp_cnt1++;
            else     resp_cnt0++;
         end
      end
   endtask

   task automatic settle();
      @(negedge clk);
      mon();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      proc0_reqstream_val  = 1'b0;
      proc1_reqstream_val  = 1'b0;
      proc0_reqstream_msg  = '0;
      proc1_reqstream_msg  = '0;
      proc0_respstream_rdy = 1'b1;
      proc1_respstream_rdy = 1'b1;
      cache_reqstream_rdy  = 1'b1;
      cache_respstream_val = 1'b0;
      cache_respstream_msg = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      settle();
      adv();
      settle();
      adv();
      reset = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      checks++;
      if ({cache_reqstream_val, proc0_reqstream_rdy, proc1_reqstream_rdy, proc0_respstream_val,
           proc1_respstream_val, cache_respstream_rdy} !== 6'b0) begin
         errors++;
         $display("FAIL %s_idle_outputs got %b want 000000", tag,
                  {cache_reqstream_val, proc0_reqstream_rdy, proc1_reqstream_rdy,
                   proc0_respstream_val, proc1_respstream_val, cache_respstream_rdy});
      end
      checks++;
      if (num_inflight !== 3'd0) begin
         errors++;
         $display("FAIL %s_idle_inflight got %0d want 0", tag, num_inflight);
      end
   endtask

   task automatic test_reset();
      do_reset();
      settle();
      check_idle("reset");
      adv();
   endtask

   task automatic test_single();
      logic [RW-1:0] m;
      logic [SW-1:0] r;
      do_reset();
      m = rnd_req();
      m[31:0] = 32'h0000_1000;
      proc0_reqstream_val = 1'b1;
      proc0_reqstream_msg = m;
      exp_req(1'b0, m);
      settle();
      checks++;
      if (cache_reqstream_val !== 1'b1 || cache_reqstream_msg !== m || proc0_reqstream_rdy !== 1'b1) begin
         errors++;
         $display("FAIL single_req got val=%b rdy0=%b msg=%h want 1 1 %h",
                  cache_reqstream_val, proc0_reqstream_rdy, cache_reqstream_msg, m);
      end
      checks++;
      if (num_inflight !== 3'd0) begin
         errors++;
         $display("FAIL single_inflight0 got %0d want 0", num_inflight);
      end
      adv();
      proc0_reqstream_val  = 1'b0;
      r = rnd_resp();
      cache_respstream_val = 1'b1;
      cache_respstream_msg = r;
      exp_resp(1'b0, r);
      settle();
      checks++;
      if (num_inflight !== 3'd1) begin
         errors++;
         $display("FAIL single_inflight1 got %0d want 1", num_inflight);
      end
      checks++;
      if (proc0_respstream_val !== 1'b1 || proc1_respstream_val !== 1'b0) begin
         errors++;
         $display("FAIL single_resp_route got val0=%b val1=%b want 1 0",
                  proc0_respstream_val, proc1_respstream_val);
      end
      adv();
      idle_inputs();
      settle();
      checks++;
      if (num_inflight !== 3'd0) begin
         errors++;
         $display("FAIL single_inflight_end got %0d want 0", num_inflight);
      end
      adv();
   endtask

   task automatic test_alternation();
      logic          g, prev_g;
      logic [RW-1:0] a, b;
      logic [SW-1:0] r;
      do_reset();
      resp_cnt0 = 0;
      resp_cnt1 = 0;
      prev_g = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         g = i[0];
         if (i < 8) begin
            a = rnd_req();
            b = rnd_req();
            proc0_reqstream_val = 1'b1;
            proc1_reqstream_val = 1'b1;
            proc0_reqstream_msg = a;
            proc1_reqstream_msg = b;
            exp_req(g, g ? b : a);
         end else begin
            proc0_reqstream_val = 1'b0;
            proc1_reqstream_val = 1'b0;
         end
         if (i > 0) begin
            r = rnd_resp();
            cache_respstream_val = 1'b1;
            cache_respstream_msg = r;
            exp_resp(prev_g, r);
         end
         settle();
         checks++;
         if (num_inflight !== ((i > 0) ? 3'd1 : 3'd0)) begin
            errors++;
            $display("FAIL alt_inflight cycle %0d got %0d want %0d", i, num_inflight, (i > 0) ? 1 : 0);
         end
         adv();
         prev_g = g;
      end
      idle_inputs();
      settle();
      checks++;
      if (resp_cnt0 !== 4 || resp_cnt1 !== 4) begin
         errors++;
         $display("FAIL alt_resp_counts got %0d/%0d want 4/4", resp_cnt0, resp_cnt1);
      end
      checks++;
      if (num_inflight !== 3'd0) begin
         errors++;
         $display("FAIL alt_inflight_end got %0d want 0", num_inflight);
      end
      adv();
   endtask

   task automatic test_prio_lone();
      logic [RW-1:0] a, b;
      logic [SW-1:0] r;
      do_reset();
      b = rnd_req();
      proc1_reqstream_val = 1'b1;
      proc1_reqstream_msg = b;
      exp_req(1'b1, b);
      settle();
      adv();
      a = rnd_req();
      proc0_reqstream_val  = 1'b1;
      proc0_reqstream_msg  = a;
      r = rnd_resp();
      cache_respstream_val = 1'b1;
      cache_respstream_msg = r;
      exp_req(1'b0, a);
      exp_resp(1'b1, r);
      settle();
      checks++;
      if (proc0_reqstream_rdy !== 1'b1 || proc1_reqstream_rdy !== 1'b0) begin
         errors++;
         $display("FAIL prio_cycle2 got rdy0=%b rdy1=%b want 1 0", proc0_reqstream_rdy, proc1_reqstream_rdy);
      end
      adv();
      b = rnd_req();
      proc1_reqstream_msg  = b;
      r = rnd_resp();
      cache_respstream_msg = r;
      exp_req(1'b1, b);
      exp_resp(1'b0, r);
      settle();
      checks++;
      if (proc1_reqstream_rdy !== 1'b1 || proc0_reqstream_rdy !== 1'b0) begin
         errors++;
         $display("FAIL prio_cycle3 got rdy0=%b rdy1=%b want 0 1", proc0_reqstream_rdy, proc1_reqstream_rdy);
      end
      adv();
      proc0_reqstream_val  = 1'b0;
      proc1_reqstream_val  = 1'b0;
      r = rnd_resp();
      cache_respstream_msg = r;
      exp_resp(1'b1, r);
      settle();
      adv();
      idle_inputs();
   endtask

   task automatic test_full();
      logic [RW-1:0] a, b;
      logic [SW-1:0] r;
      do_reset();
      a = rnd_req();
      b = rnd_req();
      proc0_reqstream_val = 1'b1;
      proc1_reqstream_val = 1'b1;
      proc0_reqstream_msg = a;
      proc1_reqstream_msg = b;
      exp_req(1'b0, a);
      settle();
      adv();
      exp_req(1'b1, b);
      settle();
      adv();
      r = rnd_resp();
      cache_respstream_val = 1'b1;
      cache_respstream_msg = r;
      exp_resp(1'b0, r);
      settle();
      checks++;
      if (num_inflight !== 3'd2) begin
         errors++;
         $display("FAIL full_inflight got %0d want 2", num_inflight);
      end
      checks++;
      if ({cache_reqstream_val, proc0_reqstream_rdy, proc1_reqstream_rdy} !== 3'b000) begin
         errors++;
         $display("FAIL full_blocked got val/rdy0/rdy1=%b want 000",
                  {cache_reqstream_val, proc0_reqstream_rdy, proc1_reqstream_rdy});
      end
      checks++;
      if (cache_respstream_rdy !== 1'b1) begin
         errors++;
         $display("FAIL full_pop_rdy got %b want 1", cache_respstream_rdy);
      end
      adv();
      cache_respstream_val = 1'b0;
      exp_req(1'b0, a);
      settle();
      checks++;
      if (cache_reqstream_val !== 1'b1 || proc0_reqstream_rdy !== 1'b1 || num_inflight !== 3'd1) begin
         errors++;
         $display("FAIL full_third_req got val=%b rdy0=%b inflight=%0d want 1 1 1",
                  cache_reqstream_val, proc0_reqstream_rdy, num_inflight);
      end
      adv();
      proc0_reqstream_val  = 1'b0;
      proc1_reqstream_val  = 1'b0;
      cache_respstream_val = 1'b1;
      r = rnd_resp();
      cache_respstream_msg = r;
      exp_resp(1'b1, r);
      settle();
      adv();
      r = rnd_resp();
      cache_respstream_msg = r;
      exp_resp(1'b0, r);
      settle();
      adv();
      idle_inputs();
      settle();
      checks++;
      if (num_inflight !== 3'd0) begin
         errors++;
         $display("FAIL full_inflight_end got %0d want 0", num_inflight);
      end
      adv();
   endtask

   task automatic test_hol();
      logic [RW-1:0] a, b;
      logic [SW-1:0] r0, r1;
      do_reset();
      a = rnd_req();
      b = rnd_req();
      proc0_reqstream_val = 1'b1;
      proc0_reqstream_msg = a;
      exp_req(1'b0, a);
      settle();
      adv();
      proc0_reqstream_val = 1'b0;
      proc1_reqstream_val = 1'b1;
      proc1_reqstream_msg = b;
      exp_req(1'b1, b);
      settle();
      adv();
      proc1_reqstream_val  = 1'b0;
      r0 = rnd_resp();
      cache_respstream_val = 1'b1;
      cache_respstream_msg = r0;
      proc0_respstream_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++;
         if (cache_respstream_rdy !== 1'b0 || proc1_respstream_val !== 1'b0 ||
             proc0_respstream_val !== 1'b1 || num_inflight !== 3'd2) begin
            errors++;
            $display("FAIL hol_stall cycle %0d got crdy=%b val1=%b val0=%b inflight=%0d want 0 0 1 2",
                     i, cache_respstream_rdy, proc1_respstream_val, proc0_respstream_val, num_inflight);
         end
         adv();
      end
      proc0_respstream_rdy = 1'b1;
      exp_resp(1'b0, r0);
      settle();
      adv();
      r1 = rnd_resp();
      cache_respstream_msg = r1;
      exp_resp(1'b1, r1);
      settle();
      checks++;
      if (proc1_respstream_val !== 1'b1 || proc0_respstream_val !== 1'b0) begin
         errors++;
         $display("FAIL hol_second got val0=%b val1=%b want 0 1", proc0_respstream_val, proc1_respstream_val);
      end
      adv();
      idle_inputs();
      settle();
      checks++;
      if (num_inflight !== 3'd0) begin
         errors++;
         $display("FAIL hol_inflight_end got %0d want 0", num_inflight);
      end
      adv();
   endtask

   task automatic test_reset_mid();
      logic [RW-1:0] a, b;
      logic [SW-1:0] r;
      do_reset();
      // proc1 then proc0 leaves prio at 1 and two IDs queued before the reset.
      b = rnd_req();
      proc1_reqstream_val = 1'b1;
      proc1_reqstream_msg = b;
      exp_req(1'b1, b);
      settle();
      adv();
      a = rnd_req();
      proc1_reqstream_val = 1'b0;
      proc0_reqstream_val = 1'b1;
      proc0_reqstream_msg = a;
      exp_req(1'b0, a);
      settle();
      adv();
      idle_inputs();
      reset = 1'b1;
      settle();
      adv();
      reset = 1'b0;
      settle();
      check_idle("midreset");
      adv();
      a = rnd_req();
      b = rnd_req();
      proc0_reqstream_val = 1'b1;
      proc1_reqstream_val = 1'b1;
      proc0_reqstream_msg = a;
      proc1_reqstream_msg = b;
      exp_req(1'b0, a);
      settle();
      checks++;
      if (proc0_reqstream_rdy !== 1'b1 || proc1_reqstream_rdy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_prio got rdy0=%b rdy1=%b want 1 0", proc0_reqstream_rdy, proc1_reqstream_rdy);
      end
      adv();
      proc0_reqstream_val  = 1'b0;
      b = rnd_req();
      proc1_reqstream_msg  = b;
      exp_req(1'b1, b);
      r = rnd_resp();
      cache_respstream_val = 1'b1;
      cache_respstream_msg = r;
      exp_resp(1'b0, r);
      settle();
      adv();
      proc1_reqstream_val  = 1'b0;
      r = rnd_resp();
      cache_respstream_msg = r;
      exp_resp(1'b1, r);
      settle();
      checks++;
      if (proc1_respstream_val !== 1'b1 || proc0_respstream_val !== 1'b0) begin
         errors++;
         $display("FAIL midreset_route got val0=%b val1=%b want 0 1", proc0_respstream_val, proc1_respstream_val);
      end
      adv();
      idle_inputs();
      settle();
      checks++;
      if (num_inflight !== 3'd0) begin
         errors++;
         $display("FAIL midreset_inflight_end got %0d want 0", num_inflight);
      end
      adv();
   endtask

   task automatic test_empty_resp();
      do_reset();
      cache_respstream_val = 1'b1;
      cache_respstream_msg = rnd_resp();
      settle();
      checks++;
      if ({cache_respstream_rdy, proc0_respstream_val, proc1_respstream_val} !== 3'b000) begin
         errors++;
         $display("FAIL empty_resp got crdy/val0/val1=%b want 000",
                  {cache_respstream_rdy, proc0_respstream_val, proc1_respstream_val});
      end
      adv();
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_single();
      test_alternation();
      test_prio_lone();
      test_full();
      test_hol();
      test_reset_mid();
      test_empty_resp();
      checks++;
      if (exp_req_id.size() != 0 || exp_resp_id.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d req / %0d resp pending want 0/0",
                  exp_req_id.size(), exp_resp_id.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
